// File: rtl/gcd_xcel.sv
// gcd_xcel: iterative 16-bit GCD accelerator using Euclid's subtract/swap
// algorithm, with a small circular response FIFO so a new request can be
// accepted before earlier results are read.
// Optional feature: define GCD_CYCLE_COUNT_EN to add the cyc_cnt output, which
// reports how many CALC cycles the last completed computation took.
module gcd_xcel #(
  parameter int W          = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           req_val,
  output logic           req_rdy,
  input  logic [2*W-1:0] req_msg,
  output logic           resp_val,
  input  logic           resp_rdy,
  output logic [W-1:0]   resp_msg
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [W-1:0]   cyc_cnt
`endif
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = RESP_DEPTH[PW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_mem [RESP_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic          w_req_fire;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_a_lt_b;
  logic          w_b_zero;

  assign w_a_lt_b = (r_a < r_b);
  assign w_b_zero = (r_b == '0);
  assign w_full   = (r_count == DEPTH_C);

  // State register; reset aborts any computation in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: accept, iterate until B reaches zero, then wait for FIFO space.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req_fire) w_next_state = CALC;
      CALC:    if (!w_a_lt_b && w_b_zero) w_next_state = DONE;
      DONE:    if (w_push) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output and handshake decode; a full FIFO still has space if it pops this cycle.
  always_comb begin
    req_rdy    = (r_state == IDLE);
    resp_val   = (r_count != '0);
    resp_msg   = r_mem[r_rd_ptr];
    w_req_fire = req_val && req_rdy;
    w_pop      = resp_val && resp_rdy;
    w_push     = (r_state == DONE) && (!w_full || w_pop);
  end

  // Operand registers: latch on accept, then one swap or subtract per CALC cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_req_fire) begin
      r_a <= req_msg[2*W-1:W];
      r_b <= req_msg[W-1:0];
    end else if (r_state == CALC) begin
      if (w_a_lt_b) begin
        r_a <= r_b;
        r_b <= r_a;
      end else if (!w_b_zero) begin
        r_a <= r_a - r_b;
      end
    end
  end

  // Response FIFO: circular buffer; the result is A while the FSM sits in DONE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < RESP_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_a;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [W-1:0] r_calc_cnt;
  logic [W-1:0] w_cnt_inc;

  assign w_cnt_inc = (&r_calc_cnt) ? r_calc_cnt : (r_calc_cnt + 1'b1);

  // Saturating CALC-cycle counter; the total is published when entering DONE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_calc_cnt <= '0;
      cyc_cnt    <= '0;
    end else if (w_req_fire) begin
      r_calc_cnt <= '0;
    end else if (r_state == CALC) begin
      r_calc_cnt <= w_cnt_inc;
      if (!w_a_lt_b && w_b_zero) cyc_cnt <= w_cnt_inc;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_xcel.sv
// tb_gcd_xcel: directed scoreboard bench for gcd_xcel. Requests push their
// hand-computed result into a queue; a monitor pops and compares on every
// response transfer. Cycle-accurate checks cover latency, back-pressure,
// simultaneous push/pop and reset.
module tb_gcd_xcel;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_val;
  logic           req_rdy;
  logic [2*W-1:0] req_msg;
  logic           resp_val;
  logic           resp_rdy;
  logic [W-1:0]   resp_msg;
`ifdef GCD_CYCLE_COUNT_EN
  logic [W-1:0]   cyc_cnt;
`endif

  int             nChecks = 0;
  int             nFails  = 0;
  logic [W-1:0]   expQ[$];

  always #5 clk = ~clk;

  gcd_xcel #(.W(W), .RESP_DEPTH(2)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cyc_cnt  (cyc_cnt)
`endif
  );

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Number of CALC cycles the subtract/swap algorithm needs.
  function automatic int gcdSteps(input int a, input int b);
    int n = 0;
    int t;
    forever begin
      n++;
      if (a < b) begin
        t = a; a = b; b = t;
      end else if (b != 0) begin
        a = a - b;
      end else begin
        break;
      end
    end
    return n;
  endfunction

  // Bounded wait for req_rdy.
  task automatic waitReqRdy(input int bound);
    int k = 0;
    while (!req_rdy && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkOutput("req_rdy wait", 32'(req_rdy), 32'd1);
  endtask

  // Bounded wait for resp_val.
  task automatic waitRespVal(input int bound);
    int k = 0;
    while (!resp_val && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkOutput("resp_val wait", 32'(resp_val), 32'd1);
  endtask

  // Issue one request (called at a negedge, returns one negedge after transfer).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expected, input bit track);
    waitReqRdy(70000);
    req_msg = {a, b};
    req_val = 1'b1;
    if (track) expQ.push_back(expected);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  // Scoreboard monitor: compare the head result on each response transfer.
  always @(negedge clk) begin
    #1;
    if (!rst && resp_val && resp_rdy) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected response: got %0d, expected none", resp_msg);
      end else begin
        checkOutput("scoreboard", 32'(resp_msg), 32'(expQ.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [W-1:0] vecA [6] = '{16'd10, 16'd7, 16'd9, 16'd20, 16'd14, 16'd0};
  logic [W-1:0] vecB [6] = '{16'd4,  16'd3, 16'd6, 16'd15, 16'd21, 16'd5};
  logic [W-1:0] vecE [6] = '{16'd2,  16'd1, 16'd3, 16'd5,  16'd7,  16'd5};

  initial begin
    int k;
    rst      = 1'b1;
    req_val  = 1'b0;
    resp_rdy = 1'b0;
    req_msg  = '0;
    #12;
    checkOutput("reset req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("reset resp_val", 32'(resp_val), 32'd0);
    checkOutput("reset resp_msg", 32'(resp_msg), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Queue one result, start another, then reset asynchronously mid-CALC.
    applyStimulus(16'd6, 16'd4, 16'd2, 1'b0);
    waitRespVal(50);
    applyStimulus(16'd15, 16'd5, 16'd5, 1'b0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("async reset resp_val", 32'(resp_val), 32'd0);
    checkOutput("async reset resp_msg", 32'(resp_msg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("post reset resp_val", 32'(resp_val), 32'd0);
    checkOutput("post reset req_rdy", 32'(req_rdy), 32'd1);

    // Latency for (15,5): response visible 7 cycles after the transfer.
    applyStimulus(16'd15, 16'd5, 16'd5, 1'b1);
    k = 1;
    while (!resp_val && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("latency 15,5", 32'(k), 32'd7);
    checkOutput("latency resp_msg", 32'(resp_msg), 32'd5);
    checkOutput("latency req_rdy", 32'(req_rdy), 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
    checkOutput("cyc_cnt 15,5", 32'(cyc_cnt), 32'd5);
`endif
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    checkOutput("latency drained", 32'(resp_val), 32'd0);

    // Edge operands, consumer always ready.
    resp_rdy = 1'b1;
    applyStimulus(16'd0,     16'd0,     16'd0,     1'b1);
    applyStimulus(16'd0,     16'd9,     16'd9,     1'b1);
    applyStimulus(16'd9,     16'd0,     16'd9,     1'b1);
    applyStimulus(16'd1,     16'd65535, 16'd1,     1'b1);
    applyStimulus(16'd65535, 16'd65535, 16'd65535, 1'b1);
    k = 0;
    while (expQ.size() > 0 && k < 70000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("edge drain", 32'(expQ.size()), 32'd0);
    resp_rdy = 1'b0;

    // Back-pressure: fill FIFO, third result holds in DONE.
    applyStimulus(16'd12, 16'd8,  16'd4, 1'b1);
    applyStimulus(16'd21, 16'd14, 16'd7, 1'b1);
    applyStimulus(16'd48, 16'd18, 16'd6, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("bp hold req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("bp resp_val", 32'(resp_val), 32'd1);
    checkOutput("bp head", 32'(resp_msg), 32'd4);
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    checkOutput("bp released req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("bp head after pop", 32'(resp_msg), 32'd7);
    resp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    resp_rdy = 1'b0;
    checkOutput("bp drained", 32'(resp_val), 32'd0);

    // Simultaneous push/pop in the DONE cycle with one entry queued.
    applyStimulus(16'd8, 16'd4, 16'd4, 1'b1);
    waitRespVal(50);
    for (int r = 0; r < 6; r++) begin
      applyStimulus(vecA[r], vecB[r], vecE[r], 1'b1);
      repeat (gcdSteps(int'(vecA[r]), int'(vecB[r]))) @(negedge clk);
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
      checkOutput("pushpop resp_val", 32'(resp_val), 32'd1);
      checkOutput("pushpop req_rdy", 32'(req_rdy), 32'd1);
      checkOutput("pushpop head", 32'(resp_msg), 32'(vecE[r]));
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    checkOutput("pushpop drained", 32'(resp_val), 32'd0);

    // Ignored handshakes: pop on empty, request during CALC.
    resp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    resp_rdy = 1'b0;
    checkOutput("empty pop resp_val", 32'(resp_val), 32'd0);
    applyStimulus(16'd15, 16'd5, 16'd5, 1'b1);
    req_msg = {16'd100, 16'd10};
    req_val = 1'b1;
    checkOutput("calc req_rdy", 32'(req_rdy), 32'd0);
    repeat (2) @(negedge clk);
    req_val = 1'b0;
    waitRespVal(50);
    checkOutput("ignored req result", 32'(resp_msg), 32'd5);
`ifdef GCD_CYCLE_COUNT_EN
    checkOutput("ignored req cyc_cnt", 32'(cyc_cnt), 32'd5);
`endif
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("final resp_val", 32'(resp_val), 32'd0);
    checkOutput("final scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
